// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encoding, reset defaults and sizing helpers for the PWM controller
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } state_t;

    localparam int DUTY_RST = 0;

    // Reset period is the full counter range, i.e. all ones for a w-bit counter.
    function automatic int period_rst(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic int ch_idx_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel_cmp.sv
// rtl/pwm_channel_cmp.sv - per-channel duty compare with registered PWM output
module pwm_channel_cmp
    import pwm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] duty_act,
    output logic             pwm
);

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            pwm <= 1'b0;
        end else begin
            pwm <= (cnt < duty_act);
        end
    end

endmodule

// File: rtl/pwm_controller.sv
// rtl/pwm_controller.sv - multi-channel PWM scheduler with shadowed period/duty configuration
module pwm_controller
    import pwm_pkg::*;
#(
    parameter int CH    = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic                     cfg_is_period,
    input  logic [ch_idx_w(CH)-1:0]  cfg_ch,
    input  logic [CNT_W-1:0]         cfg_data,
    input  logic                     cfg_commit,
    output logic [CH-1:0]            pwm_out,
    output logic                     period_tick,
    output logic                     busy_pending
);

    localparam int CHW = ch_idx_w(CH);
    localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(period_rst(CNT_W));
    localparam logic [CNT_W-1:0] DUTY_RST_V = CNT_W'(DUTY_RST);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] period_sh;
    logic [CNT_W-1:0] period_sh_nx;
    logic [CNT_W-1:0] duty_act   [CH];
    logic [CNT_W-1:0] duty_sh    [CH];
    logic [CNT_W-1:0] duty_sh_nx [CH];

    logic wr_acc;
    logic commit_acc;
    logic wrap;
    logic apply;
    logic run;

    assign cfg_ready    = (state != PENDING);
    assign busy_pending = (state == PENDING);
    assign period_tick  = wrap;

    // The next-shadow view lets a write and a commit in the same cycle land together.
    always_comb begin
        wr_acc     = cfg_valid && cfg_ready;
        commit_acc = cfg_commit && cfg_ready;
        wrap       = (state != IDLE) && (cnt == period_act);
        run        = en && (state != IDLE);

        period_sh_nx = period_sh;
        if (wr_acc && cfg_is_period) begin
            period_sh_nx = cfg_data;
        end

        for (int i = 0; i < CH; i++) begin
            duty_sh_nx[i] = duty_sh[i];
            if (wr_acc && !cfg_is_period && (cfg_ch == CHW'(i))) begin
                duty_sh_nx[i] = cfg_data;
            end
        end

        // A commit takes effect at once when not counting; a pending one waits for
        // the wrap, or is flushed when the block is being stopped.
        apply = (commit_acc && ((state == IDLE) || !en))
              || ((state == PENDING) && (wrap || !en));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            period_act <= PERIOD_RST;
            period_sh  <= PERIOD_RST;
            for (int i = 0; i < CH; i++) begin
                duty_act[i] <= DUTY_RST_V;
                duty_sh[i]  <= DUTY_RST_V;
            end
        end else begin
            period_sh <= period_sh_nx;
            for (int i = 0; i < CH; i++) begin
                duty_sh[i] <= duty_sh_nx[i];
            end

            if (apply) begin
                period_act <= period_sh_nx;
                for (int i = 0; i < CH; i++) begin
                    duty_act[i] <= duty_sh_nx[i];
                end
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= wrap ? '0 : cnt + CNT_W'(1);
                        if (commit_acc) begin
                            state <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (!en) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= wrap ? '0 : cnt + CNT_W'(1);
                        if (wrap) begin
                            state <= RUN;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        pwm_channel_cmp #(
            .CNT_W(CNT_W)
        ) u_cmp (
            .clk      (clk),
            .rst      (rst),
            .run      (run),
            .cnt      (cnt),
            .duty_act (duty_act[i]),
            .pwm      (pwm_out[i])
        );
    end

endmodule

// File: doc/pwm_controller.md
Name: pwm_controller

Overview:
- Multi-channel PWM scheduler that sequences a shared period counter and per-channel compare/output-flop datapaths.
- Owns the configuration path: period and duty values are written into shadow registers over a valid/ready handshake.
- Shadow values go live only at a period boundary (glitch-free update).
- Sits between a host/config bus and the board-level PWM pins.

Parameters:
- CH, 4, number of PWM channels (2..8).
- CNT_W, 8, width of the period counter and of the period/duty registers.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; low forces the block idle.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  block can accept a config write or commit.
- cfg_is_period  in  1  1 = write period shadow, 0 = write duty shadow of cfg_ch.
- cfg_ch  in  $clog2(CH)  target channel for duty writes; ignored for period writes.
- cfg_data  in  CNT_W  value written.
- cfg_commit  in  1  request transfer of all shadows to active registers.
- pwm_out  out  CH  registered PWM outputs.
- period_tick  out  1  one-cycle pulse on the last count of each period.
- busy_pending  out  1  a commit is waiting for the period boundary.

Behaviour:
- Reset values:
  - cnt=0; period_act=period_sh=2^CNT_W-1; all duty_act/duty_sh=0.
  - pwm_out=0, period_tick=0, busy_pending=0, cfg_ready=1, state=IDLE.
- States: IDLE, RUN, PENDING.
- IDLE:
  - cnt held at 0; pwm_out=0; period_tick=0.
  - Moves to RUN on the first cycle en=1; counting starts from cnt=0.
- RUN:
  - cnt increments each cycle.
  - When cnt==period_act, cnt wraps to 0 and period_tick=1 in the same cycle.
- Config write:
  - Accepted when cfg_valid&cfg_ready.
  - Writes period_sh or duty_sh[cfg_ch]; the active registers are not affected.
- Commit:
  - Accepted when cfg_commit&cfg_ready.
  - In IDLE: shadows copy to the active registers on the next edge; cfg_ready stays 1.
  - In RUN: go to PENDING; cfg_ready=0 and busy_pending=1 from the next cycle.
- PENDING:
  - Counting continues.
  - On the wrap edge (cnt==period_act): shadows copy to active, state returns to RUN, cfg_ready=1 and busy_pending=0 on the following cycle.
  - The new period starts with cnt=0 under the new values.
- Simultaneous cfg_valid and cfg_commit in the same accepted cycle: the write lands in the shadow first, and the commit includes it.
- cfg_valid while cfg_ready=0: ignored, no write. The host must hold cfg_valid until it sees cfg_ready.
- PWM compare:
  - pwm_out[i] next = (cnt < duty_act[i]), registered, so one cycle of latency after cnt.
  - duty=0 gives constant 0.
  - duty > period_act gives constant 1 (100%).
  - High time per period = min(duty, period+1) cycles.
- period_act=0: period is 1 cycle; period_tick stays high continuously; duty>=1 gives constant 1.
- en falls:
  - In RUN or PENDING: go to IDLE next edge; pwm_out cleared on that edge.
  - A pending commit is applied on that same edge, then cfg_ready=1.
- rst asserted mid-operation: all registers return to reset values on that edge, including shadows; a pending commit is discarded.
- Arithmetic: unsigned CNT_W-bit throughout; no overflow, since cnt never exceeds period_act.

Decomposition:
- Package pwm_pkg:
  - State enum {IDLE, RUN, PENDING}.
  - Reset-default constants for period and duty.
  - Helper function for the channel-index width.
- Sub-module pwm_channel_cmp (one instance per channel):
  - Inputs: cnt, duty_act, run.
  - Holds the compare and the output flop for pwm_out[i]; output cleared on rst or when run=0.
- The controller keeps the counter, FSM, shadow/active register banks and handshake.

Test Plan:
- Reset then en=1, defaults (period 255, duty 0) -> pwm_out=0 throughout; period_tick every 256 cycles; cfg_ready=1.
- In IDLE: write period=9, ch0 duty=3, ch1 duty=10, then commit, then en=1 -> ch0 high 3 of every 10 cycles; ch1 constant 1; period_tick every 10 cycles; pwm_out lags cnt by 1 cycle.
- In RUN (period 9): write ch0 duty=7, commit at cnt=4 -> cfg_ready=0 and busy_pending=1 until the wrap; ch0 keeps 3/10 through the current period, then 7/10. A cfg_valid during PENDING is ignored.
- Same-cycle cfg_valid (ch2 duty=5) and cfg_commit in RUN -> ch2 shows 5/10 from the next period.
- en dropped while PENDING -> pwm_out=0 next cycle; active registers updated; cfg_ready=1. On re-enable the new values are used from cnt=0.
- rst pulsed mid-period with duty 7 active -> all outputs 0; period back to 255; duties 0; state IDLE.
